// File: rtl/peregrine_iram_gen2.sv
// Single-port instruction RAM shared between core and loader, with starvation-bounded arbitration.
// Optional per-byte even parity with IRamParityErr when PEREGRINE_IRAM_PARITY_EN is defined.
module peregrine_iram_gen2 #(
  parameter int WIDTH   = 32,
  parameter int AWIDTH  = 17,
  parameter int LATENCY = 1,
  parameter int STARVE  = 8
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [AWIDTH-1:0] IRamAddr,
  input  logic              IRamEn,
  input  logic              IRamWr,
  input  logic [WIDTH/8-1:0] IRamByteEn,
  input  logic [WIDTH-1:0]  IRamWrData,
  input  logic              IRamLoadStore,
  output logic [WIDTH-1:0]  IRamData,
  output logic              IRamBusy,
  input  logic              LdReq,
  input  logic [AWIDTH-1:0] LdAddr,
  input  logic              LdWr,
  input  logic [WIDTH-1:0]  LdWrData,
  output logic              LdAck,
  output logic [WIDTH-1:0]  LdRdData,
  output logic              LdRdValid
`ifdef PEREGRINE_IRAM_PARITY_EN
  ,
  output logic              IRamParityErr
`endif
);

  localparam int NB    = WIDTH / 8;
  localparam int DEPTH = 1 << AWIDTH;
  localparam int CW    = $clog2(STARVE + 1);

  typedef enum logic {ARB_CORE, ARB_LOADER} arb_t;

  arb_t            state, state_nxt;
  logic [CW-1:0]   wait_cnt;
  logic            ld_grant, core_go, rd_go, wr_go;
  logic [AWIDTH-1:0] arr_addr;
  logic [WIDTH-1:0]  arr_wdata;
  logic [NB-1:0]     arr_be;

  // Fetch vs load/store makes no difference to how the array is accessed.
  logic unused_ls;
  assign unused_ls = IRamLoadStore;

  always_ff @(posedge CLK) begin
    if (Reset) state <= ARB_CORE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_grant  = 1'b0;
    if (!Reset) begin
      case (state)
        ARB_CORE: begin
          if (LdReq && !IRamEn)
            ld_grant = 1'b1;
          else if (LdReq && wait_cnt == CW'(STARVE))
            state_nxt = ARB_LOADER;
        end
        ARB_LOADER: begin
          ld_grant  = LdReq;
          state_nxt = ARB_CORE;
        end
        default: state_nxt = ARB_CORE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset || ld_grant || !LdReq) wait_cnt <= '0;
    else if (wait_cnt != CW'(STARVE)) wait_cnt <= wait_cnt + 1'b1;
  end

  assign core_go   = IRamEn && !ld_grant && !Reset;
  assign LdAck     = ld_grant;
  assign IRamBusy  = IRamEn && ld_grant;
  assign rd_go     = (core_go && !IRamWr) || (ld_grant && !LdWr);
  assign wr_go     = (core_go && IRamWr) || (ld_grant && LdWr);
  assign arr_addr  = ld_grant ? LdAddr : IRamAddr;
  assign arr_wdata = ld_grant ? LdWrData : IRamWrData;
  assign arr_be    = ld_grant ? {NB{1'b1}} : IRamByteEn;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (wr_go)
      for (int b = 0; b < NB; b++)
        if (arr_be[b]) mem[arr_addr][b*8 +: 8] <= arr_wdata[b*8 +: 8];
  end

  // Stage i holds a read granted i cycles ago; tag 1 marks a loader read.
  logic [LATENCY:1]            vld_pipe, tag_pipe;
  logic [LATENCY:1][WIDTH-1:0] dat_pipe;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      vld_pipe[1] <= rd_go;
      tag_pipe[1] <= ld_grant;
      for (int i = LATENCY; i > 1; i--) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (rd_go) dat_pipe[1] <= mem[arr_addr];
    for (int i = LATENCY; i > 1; i--) dat_pipe[i] <= dat_pipe[i-1];
  end

  logic             fin_core, fin_ld;
  logic [WIDTH-1:0] core_hold;

  assign fin_core = vld_pipe[LATENCY] && !tag_pipe[LATENCY];
  assign fin_ld   = vld_pipe[LATENCY] &&  tag_pipe[LATENCY];

  always_ff @(posedge CLK) begin
    if (Reset)         core_hold <= '0;
    else if (fin_core) core_hold <= dat_pipe[LATENCY];
  end

  // Outputs are forced low for the whole reset window, not just after the first edge.
  assign IRamData  = Reset ? '0 : (fin_core ? dat_pipe[LATENCY] : core_hold);
  assign LdRdValid = fin_ld && !Reset;
  assign LdRdData  = LdRdValid ? dat_pipe[LATENCY] : '0;

`ifdef PEREGRINE_IRAM_PARITY_EN
  logic [NB-1:0]             par_mem [DEPTH];
  logic [LATENCY:1][NB-1:0]  par_pipe;
  logic [NB-1:0]             par_calc;

  always_ff @(posedge CLK) begin
    if (wr_go)
      for (int b = 0; b < NB; b++)
        if (arr_be[b]) par_mem[arr_addr][b] <= ^arr_wdata[b*8 +: 8];
  end

  always_ff @(posedge CLK) begin
    if (rd_go) par_pipe[1] <= par_mem[arr_addr];
    for (int i = LATENCY; i > 1; i--) par_pipe[i] <= par_pipe[i-1];
  end

  always_comb begin
    par_calc = '0;
    for (int b = 0; b < NB; b++) par_calc[b] = ^dat_pipe[LATENCY][b*8 +: 8];
  end

  assign IRamParityErr = vld_pipe[LATENCY] && !Reset && (par_calc != par_pipe[LATENCY]);
`endif

endmodule

// File: doc/peregrine_iram_gen2.md
PEREGRINE_IRAM_GEN2 -- requirements
Module: peregrine_iram_gen2

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data word width in bits; legal values 32, 64, 128.
REQ-002 SHALL have parameter AWIDTH, default 17, meaning word-address width; depth = 2^AWIDTH words.
REQ-003 SHALL have parameter LATENCY, default 1, meaning read latency in cycles from the enable edge; legal values 1 and 2.
REQ-004 SHALL have parameter STARVE, default 8, meaning the maximum number of cycles a loader request waits while the core holds the array.
REQ-005 SHALL have port CLK, input, 1, sole clock; all logic is rising-edge.
REQ-006 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port IRamAddr, input, AWIDTH, core word address.
REQ-008 SHALL have ports IRamEn, input, 1 (core access enable) and IRamWr, input, 1 (core write qualifier).
REQ-009 SHALL have port IRamByteEn, input, WIDTH/8, core byte-lane write enables.
REQ-010 SHALL have ports IRamWrData, input, WIDTH (core write data) and IRamLoadStore, input, 1 (access is a load/store, not a fetch).
REQ-011 SHALL have ports IRamData, output, WIDTH (core read data) and IRamBusy, output, 1 (core access not accepted this cycle).
REQ-012 SHALL have ports LdReq, input, 1; LdAddr, input, AWIDTH; LdWr, input, 1; LdWrData, input, WIDTH; these form the loader request.
REQ-013 SHALL have ports LdAck, output, 1 (request accepted); LdRdData, output, WIDTH; LdRdValid, output, 1 (loader read data valid).

Function
REQ-014 Only one access SHALL reach the array per cycle; the core is granted by default.
REQ-015 The arbiter SHALL have two states: CORE and LOADER.
- CORE: loader request that has waited STARVE cycles forces LOADER next cycle.
- CORE: loader request with IRamEn low grants the loader in the same cycle, with no state change.
- LOADER: one loader beat is granted, then the arbiter returns to CORE.
REQ-016 IRamBusy SHALL be asserted combinationally in any cycle the loader is granted while IRamEn is high; the core holds its request until IRamBusy is low.
REQ-017 The wait counter SHALL saturate at STARVE, clear on LdAck, and hold at 0 while LdReq is low.
REQ-018 A granted core write SHALL update only bytes whose IRamByteEn bit is 1; loader writes SHALL update all bytes.
REQ-019 A granted read SHALL present data on IRamData or LdRdData exactly LATENCY cycles after grant; LdRdValid pulses in that cycle only.
- IRamData holds its last value until the next core read completes.
REQ-020 Read and write of the same address in one cycle cannot occur, because there is one port; a read after a write SHALL return the new data.
REQ-021 A granted write SHALL NOT produce read data; IRamData is unchanged.
REQ-022 The read pipeline SHALL carry a tag bit per stage so that loader and core read data never cross.

Reset
REQ-023 While Reset is high: arbiter = CORE, wait counter = 0, IRamBusy = 0, LdAck = 0, LdRdValid = 0, IRamData = 0, LdRdData = 0, pipeline valids cleared.
REQ-024 Reset SHALL NOT clear array contents; reads in flight when Reset is asserted are discarded and never signalled.

Configuration
REQ-025 With PEREGRINE_IRAM_PARITY_EN defined:
- one even-parity bit is stored per byte, written with that byte.
- output IRamParityErr, 1 bit, pulses aligned with IRamData or LdRdValid when any read byte mismatches; it resets to 0.
REQ-026 Without PEREGRINE_IRAM_PARITY_EN, no parity storage and no IRamParityErr port exist.

Verification
REQ-027 Core write addr 0x10 data 0xDEADBEEF ByteEn 0xF, then ByteEn 0x2 data 0x0000AA00; read 0x10 -> IRamData = 0xDEADAAEF after LATENCY cycles.
REQ-028 IRamEn held high every cycle while LdReq is high from cycle 0 (STARVE=8) -> LdAck high in cycle 9, IRamBusy high in cycle 9 only.
REQ-029 Loader read 0x20 with IRamEn low, LATENCY=2 -> LdAck in the same cycle, LdRdValid 2 cycles later with the stored word; IRamData unchanged.
REQ-030 Reset asserted one cycle after a core read grant with LATENCY=2 -> no IRamData update, all outputs 0; array word retained on re-read.
REQ-031 PARITY_EN: flip one stored data bit via backdoor, read -> IRamParityErr = 1 for exactly one cycle with the data.
